lsu_wb_master: RTL and testbench

LSU_WB_MASTER -- requirements
Module: lsu_wb_master

---
 rtl/lsu_wb_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_wb_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_master.sv
// Load/store unit bus master: accepts one RV32I load or store from the pipeline,
// runs a single classic bus cycle (cyc/stb, registered ack), formats load data
// and reports completion, misalignment and (optionally) ack timeout.
// Optional feature macro: LSU_TIMEOUT_EN (ack-wait timeout of TIMEOUT cycles).
module lsu_wb_master #(
  parameter int unsigned AWIDTH  = 5,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              l_clk,
  input  logic              l_rst,
  input  logic              l_i_valid,
  input  logic              l_i_load,
  input  logic              l_i_store,
  input  logic [2:0]        l_i_funct3,
  input  logic [31:0]       l_i_addr,
  input  logic [31:0]       l_i_wdata,
  output logic              l_o_ready,
  output logic              l_o_done,
  output logic              l_o_misaligned,
  output logic              l_o_err,
  output logic [31:0]       l_o_rdata,
  output logic              l_o_cyc,
  output logic              l_o_stb,
  output logic              l_o_we,
  output logic [3:0]        l_o_be,
  output logic [AWIDTH-1:0] l_o_load_addr,
  output logic [AWIDTH-1:0] l_o_store_addr,
  output logic [31:0]       l_o_wdata,
  input  logic [31:0]       l_i_mem_rdata,
  input  logic              l_i_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_ready;
  logic              r_done;
  logic              r_mis;
  logic              r_err;
  logic              r_cyc;
  logic              r_stb;
  logic [31:0]       r_rdata;

  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_lo;
  logic [AWIDTH-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_supported;
  logic              w_misal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_timeout;

  logic              w_done_d;
  logic              w_mis_d;
  logic              w_err_d;
  logic              w_cyc_d;
  logic              w_stb_d;
  logic [31:0]       w_rdata_d;

  logic              w_unused;

  // Address bits above the memory window are not decoded.
  assign w_unused = ^{l_i_addr[31:AWIDTH+2], 32'(TIMEOUT), 32'(DWIDTH)};

  // Load result formatting: lane select plus sign/zero extension.
  function automatic logic [31:0] f_fmt(input logic [31:0] word,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_fmt = {{24{b[7]}}, b};
      3'b100:  f_fmt = {24'd0, b};
      3'b001:  f_fmt = {{16{h[15]}}, h};
      3'b101:  f_fmt = {16'd0, h};
      default: f_fmt = word;
    endcase
  endfunction

  // Request decode: acceptance, width legality and alignment.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && l_i_valid && (l_i_load || l_i_store);
    w_supported = (l_i_funct3 == 3'b000) || (l_i_funct3 == 3'b001) ||
                  (l_i_funct3 == 3'b010) || (l_i_funct3 == 3'b100) ||
                  (l_i_funct3 == 3'b101);
    w_misal     = w_supported &&
                  (((l_i_funct3[1:0] == 2'b01) && l_i_addr[0]) ||
                   ((l_i_funct3[1:0] == 2'b10) && (l_i_addr[1:0] != 2'b00)));
  end

  // Store lane replication and byte enables; loads read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = l_i_wdata;
    if (l_i_store) begin
      case (l_i_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << l_i_addr[1:0];
          w_wdata = {4{l_i_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {l_i_addr[1], 1'b0};
          w_wdata = {2{l_i_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = l_i_wdata;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Cycles spent in WAIT; cleared everywhere else.
  always_ff @(posedge l_clk or negedge l_rst) begin
    if (!l_rst)                r_cnt <= '0;
    else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    else                       r_cnt <= '0;
  end

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    w_next    = r_state;
    w_done_d  = 1'b0;
    w_mis_d   = 1'b0;
    w_err_d   = 1'b0;
    w_cyc_d   = 1'b0;
    w_stb_d   = 1'b0;
    w_rdata_d = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_supported || w_misal) begin
            w_next   = S_DONE;
            w_done_d = 1'b1;
            w_mis_d  = w_misal;
          end else begin
            w_next  = S_REQ;
            w_cyc_d = 1'b1;
            w_stb_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_next  = S_WAIT;
        w_cyc_d = 1'b1;
      end
      S_WAIT: begin
        w_cyc_d = 1'b1;
        if (l_i_ack) begin
          w_next   = S_DONE;
          w_cyc_d  = 1'b0;
          w_done_d = 1'b1;
          if (!r_we) w_rdata_d = f_fmt(l_i_mem_rdata, r_f3, r_lo);
        end else if (w_timeout) begin
          w_next   = S_DONE;
          w_cyc_d  = 1'b0;
          w_done_d = 1'b1;
          w_err_d  = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State and status/control output registers.
  always_ff @(posedge l_clk or negedge l_rst) begin
    if (!l_rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_done  <= w_done_d;
      r_mis   <= w_mis_d;
      r_err   <= w_err_d;
      r_cyc   <= w_cyc_d;
      r_stb   <= w_stb_d;
      r_rdata <= w_rdata_d;
    end
  end

  // Request fields and bus payload, captured on accept and held through WAIT.
  always_ff @(posedge l_clk or negedge l_rst) begin
    if (!l_rst) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_lo    <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= l_i_store;
      r_f3    <= l_i_funct3;
      r_lo    <= l_i_addr[1:0];
      r_addr  <= l_i_addr[AWIDTH+1:2];
      r_be    <= w_be;
      r_wdata <= w_wdata;
    end
  end

  assign l_o_ready      = r_ready;
  assign l_o_done       = r_done;
  assign l_o_misaligned = r_mis;
  assign l_o_err        = r_err;
  assign l_o_rdata      = r_rdata;
  assign l_o_cyc        = r_cyc;
  assign l_o_stb        = r_stb;
  assign l_o_we         = r_we;
  assign l_o_be         = r_be;
  assign l_o_load_addr  = r_addr;
  assign l_o_store_addr = r_addr;
  assign l_o_wdata      = r_wdata;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed bench for lsu_wb_master with a small word memory model and an
// expected-rdata scoreboard queue.
module tb_lsu_wb_master;

  logic        l_clk = 1'b0;
  logic        l_rst;
  logic        l_i_valid, l_i_load, l_i_store;
  logic [2:0]  l_i_funct3;
  logic [31:0] l_i_addr, l_i_wdata;
  logic        l_o_ready, l_o_done, l_o_misaligned, l_o_err;
  logic [31:0] l_o_rdata;
  logic        l_o_cyc, l_o_stb, l_o_we;
  logic [3:0]  l_o_be;
  logic [4:0]  l_o_load_addr, l_o_store_addr;
  logic [31:0] l_o_wdata;
  logic [31:0] l_i_mem_rdata;
  logic        l_i_ack;

  logic        hold;
  logic [31:0] mem [0:31];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata;
  logic [31:0] exp_v;
  int          n_checks = 0;
  int          n_errors = 0;

  lsu_wb_master #(.AWIDTH(5), .DWIDTH(32), .TIMEOUT(4)) dut (
    .l_clk(l_clk), .l_rst(l_rst),
    .l_i_valid(l_i_valid), .l_i_load(l_i_load), .l_i_store(l_i_store),
    .l_i_funct3(l_i_funct3), .l_i_addr(l_i_addr), .l_i_wdata(l_i_wdata),
    .l_o_ready(l_o_ready), .l_o_done(l_o_done), .l_o_misaligned(l_o_misaligned),
    .l_o_err(l_o_err), .l_o_rdata(l_o_rdata),
    .l_o_cyc(l_o_cyc), .l_o_stb(l_o_stb), .l_o_we(l_o_we), .l_o_be(l_o_be),
    .l_o_load_addr(l_o_load_addr), .l_o_store_addr(l_o_store_addr),
    .l_o_wdata(l_o_wdata), .l_i_mem_rdata(l_i_mem_rdata), .l_i_ack(l_i_ack)
  );

  always #5 l_clk = ~l_clk;

  // Memory: registered ack and read data one cycle after cyc&stb.
  always @(posedge l_clk) begin
    l_i_ack <= l_o_cyc & l_o_stb & ~hold;
    if (l_o_cyc && l_o_stb) begin
      l_i_mem_rdata <= mem[l_o_load_addr];
      if (l_o_we)
        for (int i = 0; i < 4; i++)
          if (l_o_be[i]) mem[l_o_store_addr][8*i +: 8] <= l_o_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for ready, then present one request for a single cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int budget;
    budget = 0;
    while (!l_o_ready && budget < 20) begin
      @(negedge l_clk);
      budget++;
    end
    if (!l_o_ready) chk("ready_timeout", 32'(l_o_ready), 32'd1);
    l_i_valid  = 1'b1;
    l_i_load   = ~st;
    l_i_store  = st;
    l_i_funct3 = f3;
    l_i_addr   = addr;
    l_i_wdata  = wd;
    @(negedge l_clk);
    l_i_valid  = 1'b0;
    l_i_load   = 1'b0;
    l_i_store  = 1'b0;
  endtask

  // Full bus transaction with fixed-latency completion checks.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_bw,
                        input logic [31:0] exp_rd);
    exp_q.push_back(st ? last_rdata : exp_rd);
    issue(st, f3, addr, wd);
    chk({tag, "_req_cyc_stb"}, {30'd0, l_o_cyc, l_o_stb}, 32'd3);
    chk({tag, "_req_we"}, 32'(l_o_we), 32'(st));
    chk({tag, "_req_be"}, 32'(l_o_be), 32'(exp_be));
    chk({tag, "_req_addr"}, {22'd0, l_o_store_addr, l_o_load_addr}, {22'd0, addr[6:2], addr[6:2]});
    if (st) chk({tag, "_req_wdata"}, l_o_wdata, exp_bw);
    @(negedge l_clk);
    chk({tag, "_wait_cyc_stb_done"}, {29'd0, l_o_cyc, l_o_stb, l_o_done}, 32'd4);
    chk({tag, "_wait_be"}, 32'(l_o_be), 32'(exp_be));
    @(negedge l_clk);
    chk({tag, "_done_cyc_err"}, {29'd0, l_o_done, l_o_cyc, l_o_err}, 32'd4);
    exp_v = exp_q.pop_front();
    chk({tag, "_rdata"}, l_o_rdata, exp_v);
    last_rdata = exp_v;
    @(negedge l_clk);
    chk({tag, "_after_ready_done"}, {30'd0, l_o_ready, l_o_done}, 32'd2);
  endtask

  // Request that completes without a bus cycle.
  task automatic run_short(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic exp_mis);
    exp_q.push_back(last_rdata);
    issue(1'b0, f3, addr, 32'd0);
    chk({tag, "_done_mis_cyc_stb"}, {28'd0, l_o_done, l_o_misaligned, l_o_cyc, l_o_stb},
        {28'd0, 1'b1, exp_mis, 2'b00});
    exp_v = exp_q.pop_front();
    chk({tag, "_rdata_held"}, l_o_rdata, exp_v);
    @(negedge l_clk);
    chk({tag, "_after_ready_done_mis"}, {29'd0, l_o_ready, l_o_done, l_o_misaligned}, 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    hold = 1'b0; l_i_mem_rdata = 32'd0; l_i_ack = 1'b0;
    l_rst = 1'b0; l_i_valid = 1'b0; l_i_load = 1'b0; l_i_store = 1'b0;
    l_i_funct3 = 3'd0; l_i_addr = 32'd0; l_i_wdata = 32'd0;
    last_rdata = 32'd0;
    repeat (2) @(negedge l_clk);
    chk("rst_ctrl", {26'd0, l_o_ready, l_o_cyc, l_o_stb, l_o_we, l_o_done, l_o_misaligned}, 32'h20);
    chk("rst_err", 32'(l_o_err), 32'd0);
    chk("rst_rdata", l_o_rdata, 32'd0);
    chk("rst_bus", {l_o_wdata ^ {18'd0, l_o_be, l_o_store_addr, l_o_load_addr}}, 32'd0);
    l_rst = 1'b1;
    @(negedge l_clk);

    // Valid with neither load nor store is ignored.
    l_i_valid = 1'b1;
    @(negedge l_clk);
    l_i_valid = 1'b0;
    chk("noop_valid_ignored", {30'd0, l_o_ready, l_o_cyc}, 32'd2);

    run_op("sw_c",  1'b1, 3'b010, 32'h0000000C, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_op("lw_c",  1'b0, 3'b010, 32'h0000000C, 32'h0,        4'b1111, 32'h0,        32'hDEADBEEF);
    run_op("sb_d",  1'b1, 3'b000, 32'h0000000D, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_op("lb_d",  1'b0, 3'b000, 32'h0000000D, 32'h0,        4'b1111, 32'h0,        32'hFFFFFFA5);
    run_op("lbu_d", 1'b0, 3'b100, 32'h0000000D, 32'h0,        4'b1111, 32'h0,        32'h000000A5);
    run_op("sh_12", 1'b1, 3'b001, 32'h00000012, 32'h00008001, 4'b1100, 32'h80018001, 32'h0);
    run_op("lh_12", 1'b0, 3'b001, 32'h00000012, 32'h0,        4'b1111, 32'h0,        32'hFFFF8001);
    run_op("lhu_12",1'b0, 3'b101, 32'h00000012, 32'h0,        4'b1111, 32'h0,        32'h00008001);
    run_op("lw_c2", 1'b0, 3'b010, 32'h0000000C, 32'h0,        4'b1111, 32'h0,        32'hDEADA5EF);

    run_short("lw_mis6",  3'b010, 32'h00000006, 1'b1);
    run_short("lh_mis13", 3'b001, 32'h00000013, 1'b1);
    run_short("unsup011", 3'b011, 32'h0000000C, 1'b0);

    // Reset while waiting for ack: transfer abandoned, no done pulse.
    hold = 1'b1;
    exp_q.push_back(32'hDEADA5EF);
    issue(1'b0, 3'b010, 32'h0000000C, 32'd0);
    @(negedge l_clk);
    chk("rstwait_in_wait", {30'd0, l_o_cyc, l_o_stb}, 32'd2);
    l_rst = 1'b0;
    #1;
    chk("rstwait_async", {29'd0, l_o_ready, l_o_cyc, l_o_done}, 32'd4);
    exp_q.delete();
    last_rdata = 32'd0;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge l_clk);
      chk("rstwait_no_done", {30'd0, l_o_done, l_o_cyc}, 32'd0);
    end
    l_rst = 1'b1;
    @(negedge l_clk);
    chk("rstwait_ready", {30'd0, l_o_ready, l_o_done}, 32'd2);
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h0000000C, 32'h0, 4'b1111, 32'h0, 32'hDEADA5EF);

`ifdef LSU_TIMEOUT_EN
    // Ack withheld: four WAIT cycles, then done and err together.
    hold = 1'b1;
    exp_q.push_back(last_rdata);
    issue(1'b0, 3'b010, 32'h00000000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge l_clk);
      chk("to_wait", {29'd0, l_o_cyc, l_o_done, l_o_err}, 32'd4);
    end
    @(negedge l_clk);
    chk("to_done_err", {29'd0, l_o_cyc, l_o_done, l_o_err}, 32'd3);
    exp_v = exp_q.pop_front();
    chk("to_rdata_held", l_o_rdata, exp_v);
    hold = 1'b0;
    @(negedge l_clk);
    chk("to_ready", {30'd0, l_o_ready, l_o_err}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
